alu_reservation_station: RTL and testbench

- Buffers dispatched integer/branch/jump ops until both source operands are available, then issues one op per cycle to the combinational ALU stage (EX).
- Snoops two CDB broadcasts (ALU result, load/store result) to wake up waiting operands.
- Sits between dispatch/rename (upstream) and EX (downstream). Outputs are registered so EX sees stable inputs for a whole cycle.

---
 rtl/rs_pkg.sv | 62 ++++++
 rtl/rs_select.sv | 36 +++
 rtl/alu_reservation_station.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_pkg
// Description : Shared constants and types for the ALU reservation station and
//               the EX stage (opcode/funct encodings, entry layout, defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

    localparam int c_DEPTH_DEFAULT  = 16;
    localparam int c_ROB_W_DEFAULT  = 4;
    localparam int c_DATA_W_DEFAULT = 32;

    localparam logic [6:0] c_OPC_LUI       = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL       = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR      = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] c_OPC_ARITH     = 7'b0110011;
    localparam logic [6:0] c_OPC_ARITH_IMM = 7'b0010011;

    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_SLL  = 3'b001;
    localparam logic [2:0] c_F3_SLT  = 3'b010;
    localparam logic [2:0] c_F3_SLTU = 3'b011;
    localparam logic [2:0] c_F3_XOR  = 3'b100;
    localparam logic [2:0] c_F3_SR   = 3'b101;
    localparam logic [2:0] c_F3_OR   = 3'b110;
    localparam logic [2:0] c_F3_AND  = 3'b111;
    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    localparam logic [6:0] c_F7_NORMAL = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } rs_op_t;

    // Full entry view at the default widths.
    typedef struct packed {
        logic                          valid;
        rs_op_t                        op;
        logic [c_DATA_W_DEFAULT-1:0]   imm;
        logic [c_DATA_W_DEFAULT-1:0]   inst_addr;
        logic [c_ROB_W_DEFAULT-1:0]    rob_pos;
        logic                          rs1_ready;
        logic [c_DATA_W_DEFAULT-1:0]   rs1_val;
        logic [c_ROB_W_DEFAULT-1:0]    rs1_tag;
        logic                          rs2_ready;
        logic [c_DATA_W_DEFAULT-1:0]   rs2_val;
        logic [c_ROB_W_DEFAULT-1:0]    rs2_tag;
    } rs_entry_t;

endpackage : rs_pkg
`default_nettype wire

// File: rtl/rs_select.sv
`default_nettype none
// ============================================================================
// Module      : rs_select
// Description : Combinational one-hot picker over a candidate vector. Lowest
//               index by default; oldest via age matrix with ALU_RS_OLDEST_FIRST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_select
    import rs_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic [DEPTH-1:0]            i_cand,
`ifdef ALU_RS_OLDEST_FIRST_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
`endif
    output logic [DEPTH-1:0]            o_grant,
    output logic                        o_any
);

    assign o_any = |i_cand;

`ifdef ALU_RS_OLDEST_FIRST_EN
    // i_age[i][j] set means entry i is younger than entry j.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_oldest
            assign o_grant[gi] = i_cand[gi] & ~|(i_age[gi] & i_cand);
        end
    endgenerate
`else
    assign o_grant = i_cand & (~i_cand + DEPTH'(1));
`endif

endmodule : rs_select
`default_nettype wire

// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : alu_reservation_station
// Description : Holds integer/branch/jump ops until operands are ready, snoops
//               both CDBs and issues one op per cycle to EX through registers.
//               Define ALU_RS_OLDEST_FIRST_EN for oldest-first issue selection.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH_DEFAULT,
    parameter int ROB_W  = c_ROB_W_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              dispatch_valid_in,
    input  logic [6:0]        dispatch_opcode_in,
    input  logic [2:0]        dispatch_funct3_in,
    input  logic [6:0]        dispatch_funct7_in,
    input  logic [DATA_W-1:0] dispatch_imm_in,
    input  logic [DATA_W-1:0] dispatch_inst_addr_in,
    input  logic [ROB_W-1:0]  dispatch_rob_pos_in,
    input  logic              dispatch_rs1_ready_in,
    input  logic              dispatch_rs2_ready_in,
    input  logic [DATA_W-1:0] dispatch_rs1_val_in,
    input  logic [DATA_W-1:0] dispatch_rs2_val_in,
    input  logic [ROB_W-1:0]  dispatch_rs1_tag_in,
    input  logic [ROB_W-1:0]  dispatch_rs2_tag_in,
    output logic              rs_full_out,
    input  logic              cdb_alu_valid_in,
    input  logic [ROB_W-1:0]  cdb_alu_rob_pos_in,
    input  logic [DATA_W-1:0] cdb_alu_data_in,
    input  logic              cdb_lsb_valid_in,
    input  logic [ROB_W-1:0]  cdb_lsb_rob_pos_in,
    input  logic [DATA_W-1:0] cdb_lsb_data_in,
    output logic              transmit_to_ex_out,
    output logic [DATA_W-1:0] rs1_to_ex_out,
    output logic [DATA_W-1:0] rs2_to_ex_out,
    output logic [DATA_W-1:0] imm_to_ex_out,
    output logic [DATA_W-1:0] inst_addr_to_ex_out,
    output logic [6:0]        opcode_to_ex_out,
    output logic [6:0]        funct7_to_ex_out,
    output logic [2:0]        funct3_to_ex_out,
    output logic [ROB_W-1:0]  rob_pos_to_ex_out
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    rs_op_t            r_op      [DEPTH];
    logic [DATA_W-1:0] r_imm     [DEPTH];
    logic [DATA_W-1:0] r_pc      [DEPTH];
    logic [ROB_W-1:0]  r_rob     [DEPTH];
    logic [DEPTH-1:0]  r_rs1_rdy;
    logic [DEPTH-1:0]  r_rs2_rdy;
    logic [DATA_W-1:0] r_rs1_val [DEPTH];
    logic [DATA_W-1:0] r_rs2_val [DEPTH];
    logic [ROB_W-1:0]  r_rs1_tag [DEPTH];
    logic [ROB_W-1:0]  r_rs2_tag [DEPTH];

    logic              r_transmit;
    rs_op_t            r_op_ex;
    logic [DATA_W-1:0] r_rs1_ex;
    logic [DATA_W-1:0] r_rs2_ex;
    logic [DATA_W-1:0] r_imm_ex;
    logic [DATA_W-1:0] r_pc_ex;
    logic [ROB_W-1:0]  r_rob_ex;

    logic [DEPTH-1:0]  w_cand;
    logic [DEPTH-1:0]  w_grant;
    logic              w_any;
    logic [DEPTH-1:0]  w_free_oh;
    logic              w_dispatch;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [DATA_W:0]   w_d1;
    logic [DATA_W:0]   w_d2;

    // Returns {ready, value}, taking a same-cycle CDB result for a waiting operand.
    function automatic logic [DATA_W:0] capture(input logic rdy,
                                                input logic [DATA_W-1:0] val,
                                                input logic [ROB_W-1:0] tag);
        logic [DATA_W:0] res;
        res = {rdy, val};
        if (!rdy) begin
            if (cdb_alu_valid_in && (tag == cdb_alu_rob_pos_in)) begin
                res = {1'b1, cdb_alu_data_in};
            end else if (cdb_lsb_valid_in && (tag == cdb_lsb_rob_pos_in)) begin
                res = {1'b1, cdb_lsb_data_in};
            end
        end
        return res;
    endfunction

    assign rs_full_out = &r_valid;
    assign w_dispatch  = dispatch_valid_in && !rs_full_out;
    assign w_free_oh   = ~r_valid & (r_valid + DEPTH'(1));
    assign w_cand      = r_valid & r_rs1_rdy & r_rs2_rdy;
    assign w_d1        = capture(dispatch_rs1_ready_in, dispatch_rs1_val_in, dispatch_rs1_tag_in);
    assign w_d2        = capture(dispatch_rs2_ready_in, dispatch_rs2_val_in, dispatch_rs2_tag_in);

`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [DEPTH-1:0][DEPTH-1:0] r_age;

    // New row = everything present and staying; freeing an entry clears its column.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_age <= '0;
        end else if (flush_in) begin
            r_age <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_dispatch && w_free_oh[i]) begin
                    r_age[i] <= r_valid & ~w_grant;
                end else begin
                    r_age[i] <= r_age[i] & ~w_grant;
                end
            end
        end
    end

    rs_select #(.DEPTH(DEPTH)) u_select (
        .i_cand  (w_cand),
        .i_age   (r_age),
        .o_grant (w_grant),
        .o_any   (w_any)
    );
`else
    rs_select #(.DEPTH(DEPTH)) u_select (
        .i_cand  (w_cand),
        .o_grant (w_grant),
        .o_any   (w_any)
    );
`endif

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_sel_idx = i[IDX_W-1:0];
            end
        end
    end

    // Entry payload and operand state; meaningful only while the valid bit is set.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_dispatch && w_free_oh[i]) begin
                r_op[i]      <= '{opcode: dispatch_opcode_in,
                                  funct3: dispatch_funct3_in,
                                  funct7: dispatch_funct7_in};
                r_imm[i]     <= dispatch_imm_in;
                r_pc[i]      <= dispatch_inst_addr_in;
                r_rob[i]     <= dispatch_rob_pos_in;
                r_rs1_rdy[i] <= w_d1[DATA_W];
                r_rs1_val[i] <= w_d1[DATA_W-1:0];
                r_rs1_tag[i] <= dispatch_rs1_tag_in;
                r_rs2_rdy[i] <= w_d2[DATA_W];
                r_rs2_val[i] <= w_d2[DATA_W-1:0];
                r_rs2_tag[i] <= dispatch_rs2_tag_in;
            end else begin
                if (!r_rs1_rdy[i]) begin
                    if (cdb_alu_valid_in && (r_rs1_tag[i] == cdb_alu_rob_pos_in)) begin
                        r_rs1_rdy[i] <= 1'b1;
                        r_rs1_val[i] <= cdb_alu_data_in;
                    end else if (cdb_lsb_valid_in && (r_rs1_tag[i] == cdb_lsb_rob_pos_in)) begin
                        r_rs1_rdy[i] <= 1'b1;
                        r_rs1_val[i] <= cdb_lsb_data_in;
                    end
                end
                if (!r_rs2_rdy[i]) begin
                    if (cdb_alu_valid_in && (r_rs2_tag[i] == cdb_alu_rob_pos_in)) begin
                        r_rs2_rdy[i] <= 1'b1;
                        r_rs2_val[i] <= cdb_alu_data_in;
                    end else if (cdb_lsb_valid_in && (r_rs2_tag[i] == cdb_lsb_rob_pos_in)) begin
                        r_rs2_rdy[i] <= 1'b1;
                        r_rs2_val[i] <= cdb_lsb_data_in;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid    <= '0;
            r_transmit <= 1'b0;
            r_op_ex    <= '0;
            r_rs1_ex   <= '0;
            r_rs2_ex   <= '0;
            r_imm_ex   <= '0;
            r_pc_ex    <= '0;
            r_rob_ex   <= '0;
        end else if (flush_in) begin
            r_valid    <= '0;
            r_transmit <= 1'b0;
        end else begin
            r_valid    <= (r_valid & ~w_grant) | (w_dispatch ? w_free_oh : '0);
            r_transmit <= w_any;
            if (w_any) begin
                r_op_ex  <= r_op[w_sel_idx];
                r_rs1_ex <= r_rs1_val[w_sel_idx];
                r_rs2_ex <= r_rs2_val[w_sel_idx];
                r_imm_ex <= r_imm[w_sel_idx];
                r_pc_ex  <= r_pc[w_sel_idx];
                r_rob_ex <= r_rob[w_sel_idx];
            end
        end
    end

    assign transmit_to_ex_out  = r_transmit;
    assign rs1_to_ex_out       = r_rs1_ex;
    assign rs2_to_ex_out       = r_rs2_ex;
    assign imm_to_ex_out       = r_imm_ex;
    assign inst_addr_to_ex_out = r_pc_ex;
    assign opcode_to_ex_out    = r_op_ex.opcode;
    assign funct7_to_ex_out    = r_op_ex.funct7;
    assign funct3_to_ex_out    = r_op_ex.funct3;
    assign rob_pos_to_ex_out   = r_rob_ex;

endmodule : alu_reservation_station
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_reservation_station
// Description : Directed self-checking bench for alu_reservation_station.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_reservation_station;

    localparam int DEPTH  = 16;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;

    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_ADD  = 7'b0110011;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              flush_in;
    logic              dispatch_valid_in;
    logic [6:0]        dispatch_opcode_in;
    logic [2:0]        dispatch_funct3_in;
    logic [6:0]        dispatch_funct7_in;
    logic [DATA_W-1:0] dispatch_imm_in;
    logic [DATA_W-1:0] dispatch_inst_addr_in;
    logic [ROB_W-1:0]  dispatch_rob_pos_in;
    logic              dispatch_rs1_ready_in;
    logic              dispatch_rs2_ready_in;
    logic [DATA_W-1:0] dispatch_rs1_val_in;
    logic [DATA_W-1:0] dispatch_rs2_val_in;
    logic [ROB_W-1:0]  dispatch_rs1_tag_in;
    logic [ROB_W-1:0]  dispatch_rs2_tag_in;
    logic              rs_full_out;
    logic              cdb_alu_valid_in;
    logic [ROB_W-1:0]  cdb_alu_rob_pos_in;
    logic [DATA_W-1:0] cdb_alu_data_in;
    logic              cdb_lsb_valid_in;
    logic [ROB_W-1:0]  cdb_lsb_rob_pos_in;
    logic [DATA_W-1:0] cdb_lsb_data_in;
    logic              transmit_to_ex_out;
    logic [DATA_W-1:0] rs1_to_ex_out;
    logic [DATA_W-1:0] rs2_to_ex_out;
    logic [DATA_W-1:0] imm_to_ex_out;
    logic [DATA_W-1:0] inst_addr_to_ex_out;
    logic [6:0]        opcode_to_ex_out;
    logic [6:0]        funct7_to_ex_out;
    logic [2:0]        funct3_to_ex_out;
    logic [ROB_W-1:0]  rob_pos_to_ex_out;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    alu_reservation_station #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .flush_in              (flush_in),
        .dispatch_valid_in     (dispatch_valid_in),
        .dispatch_opcode_in    (dispatch_opcode_in),
        .dispatch_funct3_in    (dispatch_funct3_in),
        .dispatch_funct7_in    (dispatch_funct7_in),
        .dispatch_imm_in       (dispatch_imm_in),
        .dispatch_inst_addr_in (dispatch_inst_addr_in),
        .dispatch_rob_pos_in   (dispatch_rob_pos_in),
        .dispatch_rs1_ready_in (dispatch_rs1_ready_in),
        .dispatch_rs2_ready_in (dispatch_rs2_ready_in),
        .dispatch_rs1_val_in   (dispatch_rs1_val_in),
        .dispatch_rs2_val_in   (dispatch_rs2_val_in),
        .dispatch_rs1_tag_in   (dispatch_rs1_tag_in),
        .dispatch_rs2_tag_in   (dispatch_rs2_tag_in),
        .rs_full_out           (rs_full_out),
        .cdb_alu_valid_in      (cdb_alu_valid_in),
        .cdb_alu_rob_pos_in    (cdb_alu_rob_pos_in),
        .cdb_alu_data_in       (cdb_alu_data_in),
        .cdb_lsb_valid_in      (cdb_lsb_valid_in),
        .cdb_lsb_rob_pos_in    (cdb_lsb_rob_pos_in),
        .cdb_lsb_data_in       (cdb_lsb_data_in),
        .transmit_to_ex_out    (transmit_to_ex_out),
        .rs1_to_ex_out         (rs1_to_ex_out),
        .rs2_to_ex_out         (rs2_to_ex_out),
        .imm_to_ex_out         (imm_to_ex_out),
        .inst_addr_to_ex_out   (inst_addr_to_ex_out),
        .opcode_to_ex_out      (opcode_to_ex_out),
        .funct7_to_ex_out      (funct7_to_ex_out),
        .funct3_to_ex_out      (funct3_to_ex_out),
        .rob_pos_to_ex_out     (rob_pos_to_ex_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic disp_set(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [DATA_W-1:0] imm, input logic [ROB_W-1:0] rob,
                            input logic r1r, input logic [DATA_W-1:0] r1v, input logic [ROB_W-1:0] r1t,
                            input logic r2r, input logic [DATA_W-1:0] r2v, input logic [ROB_W-1:0] r2t);
        dispatch_valid_in     = 1'b1;
        dispatch_opcode_in    = opc;
        dispatch_funct3_in    = f3;
        dispatch_funct7_in    = f7;
        dispatch_imm_in       = imm;
        dispatch_inst_addr_in = 32'h1000 + {26'd0, rob, 2'b00};
        dispatch_rob_pos_in   = rob;
        dispatch_rs1_ready_in = r1r;
        dispatch_rs1_val_in   = r1v;
        dispatch_rs1_tag_in   = r1t;
        dispatch_rs2_ready_in = r2r;
        dispatch_rs2_val_in   = r2v;
        dispatch_rs2_tag_in   = r2t;
    endtask

    // Dispatch an ADD whose rs1 waits on tag t; rs2 is ready.
    task automatic disp_wait(input logic [ROB_W-1:0] rob, input logic [ROB_W-1:0] t);
        disp_set(OPC_ADD, 3'd0, 7'd0, 32'd0, rob, 1'b0, 32'd0, t, 1'b1, 32'd1, 4'd0);
        tick();
        dispatch_valid_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1;
        flush_in = 1'b0;
        dispatch_valid_in = 1'b0;
        dispatch_opcode_in = '0;
        dispatch_funct3_in = '0;
        dispatch_funct7_in = '0;
        dispatch_imm_in = '0;
        dispatch_inst_addr_in = '0;
        dispatch_rob_pos_in = '0;
        dispatch_rs1_ready_in = 1'b0;
        dispatch_rs2_ready_in = 1'b0;
        dispatch_rs1_val_in = '0;
        dispatch_rs2_val_in = '0;
        dispatch_rs1_tag_in = '0;
        dispatch_rs2_tag_in = '0;
        cdb_alu_valid_in = 1'b0;
        cdb_alu_rob_pos_in = '0;
        cdb_alu_data_in = '0;
        cdb_lsb_valid_in = 1'b0;
        cdb_lsb_rob_pos_in = '0;
        cdb_lsb_data_in = '0;

        #12;
        chk("reset_transmit", transmit_to_ex_out, 0);
        chk("reset_full", rs_full_out, 0);
        chk("reset_rob", rob_pos_to_ex_out, 0);
        chk("reset_rs1", rs1_to_ex_out, 0);
        tick();
        rst_in = 1'b0;
        tick();

        // ADDI rob 3, rs1=5, imm=7
        disp_set(OPC_ADDI, 3'd0, 7'd0, 32'd7, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0);
        tick();
        dispatch_valid_in = 1'b0;
        chk("addi_not_same_cycle", transmit_to_ex_out, 0);
        tick();
        chk("addi_transmit", transmit_to_ex_out, 1);
        chk("addi_rob", rob_pos_to_ex_out, 3);
        chk("addi_rs1", rs1_to_ex_out, 5);
        chk("addi_imm", imm_to_ex_out, 7);
        chk("addi_opcode", opcode_to_ex_out, OPC_ADDI);
        chk("addi_pc", inst_addr_to_ex_out, 32'h100C);
        tick();
        chk("idle_transmit", transmit_to_ex_out, 0);
        chk("idle_hold_rob", rob_pos_to_ex_out, 3);

        // SUB rob 4, rs1 waits on tag 2; wakes via ALU CDB
        disp_set(OPC_ADD, 3'd0, 7'b0100000, 32'd0, 4'd4, 1'b0, 32'd0, 4'd2, 1'b1, 32'd3, 4'd0);
        tick();
        dispatch_valid_in = 1'b0;
        tick();
        chk("wait_no_issue", transmit_to_ex_out, 0);
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_pos_in = 4'd2; cdb_alu_data_in = 32'h10;
        tick();
        cdb_alu_valid_in = 1'b0;
        chk("wake_not_same_cycle", transmit_to_ex_out, 0);
        tick();
        chk("wake_transmit", transmit_to_ex_out, 1);
        chk("wake_rs1", rs1_to_ex_out, 32'h10);
        chk("wake_rs2", rs2_to_ex_out, 3);
        chk("wake_funct7", funct7_to_ex_out, 7'b0100000);
        chk("wake_rob", rob_pos_to_ex_out, 4);

        // Dispatch-time capture from LSB CDB
        disp_set(OPC_ADD, 3'd4, 7'd0, 32'd0, 4'd5, 1'b1, 32'd2, 4'd0, 1'b0, 32'd0, 4'd6);
        cdb_lsb_valid_in = 1'b1; cdb_lsb_rob_pos_in = 4'd6; cdb_lsb_data_in = 32'hAB;
        tick();
        dispatch_valid_in = 1'b0;
        cdb_lsb_valid_in = 1'b0;
        tick();
        chk("capture_transmit", transmit_to_ex_out, 1);
        chk("capture_rs2", rs2_to_ex_out, 32'hAB);
        chk("capture_funct3", funct3_to_ex_out, 3'd4);
        chk("capture_rob", rob_pos_to_ex_out, 5);

        // Fill all entries; entry i waits on tag i
        for (int i = 0; i < DEPTH; i++) begin
            disp_wait(i[ROB_W-1:0], i[ROB_W-1:0]);
        end
        chk("fill_full", rs_full_out, 1);
        disp_set(OPC_ADDI, 3'd0, 7'd0, 32'd1, 4'd15, 1'b1, 32'd9, 4'd0, 1'b1, 32'd0, 4'd0);
        tick();
        dispatch_valid_in = 1'b0;
        tick();
        chk("drop_no_issue", transmit_to_ex_out, 0);
        chk("drop_still_full", rs_full_out, 1);
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_pos_in = 4'd9; cdb_alu_data_in = 32'h99;
        tick();
        cdb_alu_valid_in = 1'b0;
        chk("full_wake_full", rs_full_out, 1);
        tick();
        chk("full_issue_transmit", transmit_to_ex_out, 1);
        chk("full_issue_rob", rob_pos_to_ex_out, 9);
        chk("full_issue_rs1", rs1_to_ex_out, 32'h99);
        chk("full_drops", rs_full_out, 0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("flush1_transmit", transmit_to_ex_out, 0);

        // Age ordering: entry 5 older than re-allocated entry 1
        for (int i = 0; i < 6; i++) begin
            disp_wait(i[ROB_W-1:0], 4'(10 + i));
        end
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_pos_in = 4'd11; cdb_alu_data_in = 32'h11;
        tick();
        cdb_alu_valid_in = 1'b0;
        tick();
        chk("age_free1_rob", rob_pos_to_ex_out, 1);
        disp_wait(4'd8, 4'd7);
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_pos_in = 4'd15; cdb_alu_data_in = 32'h55;
        cdb_lsb_valid_in = 1'b1; cdb_lsb_rob_pos_in = 4'd7;  cdb_lsb_data_in = 32'h77;
        tick();
        cdb_alu_valid_in = 1'b0;
        cdb_lsb_valid_in = 1'b0;
        tick();
`ifdef ALU_RS_OLDEST_FIRST_EN
        chk("age_first_rob", rob_pos_to_ex_out, 5);
        chk("age_first_rs1", rs1_to_ex_out, 32'h55);
        tick();
        chk("age_second_rob", rob_pos_to_ex_out, 8);
        chk("age_second_rs1", rs1_to_ex_out, 32'h77);
`else
        chk("age_first_rob", rob_pos_to_ex_out, 8);
        chk("age_first_rs1", rs1_to_ex_out, 32'h77);
        tick();
        chk("age_second_rob", rob_pos_to_ex_out, 5);
        chk("age_second_rs1", rs1_to_ex_out, 32'h55);
`endif
        chk("age_second_transmit", transmit_to_ex_out, 1);

        // Four waiting remain; add four more for eight, then flush with a dispatch
        disp_wait(4'd1, 4'd0);
        disp_wait(4'd5, 4'd1);
        disp_wait(4'd6, 4'd2);
        disp_wait(4'd7, 4'd3);
        disp_set(OPC_ADDI, 3'd0, 7'd0, 32'd2, 4'd12, 1'b1, 32'd4, 4'd0, 1'b1, 32'd0, 4'd0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        dispatch_valid_in = 1'b0;
        chk("flush_full", rs_full_out, 0);
        chk("flush_transmit", transmit_to_ex_out, 0);
        tick();
        chk("flush_discard", transmit_to_ex_out, 0);
        for (int i = 0; i < 8; i++) begin
            disp_wait(i[ROB_W-1:0], 4'd15);
        end
        chk("flush_really_empty", rs_full_out, 0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;

        // Issue one op, then reset between edges
        disp_set(OPC_ADDI, 3'd1, 7'd0, 32'd5, 4'd13, 1'b1, 32'h1234, 4'd0, 1'b1, 32'd0, 4'd0);
        tick();
        dispatch_valid_in = 1'b0;
        tick();
        chk("pre_rst_transmit", transmit_to_ex_out, 1);
        chk("pre_rst_rs1", rs1_to_ex_out, 32'h1234);
        #3;
        rst_in = 1'b1;
        #1;
        chk("async_rst_transmit", transmit_to_ex_out, 0);
        chk("async_rst_rob", rob_pos_to_ex_out, 0);
        chk("async_rst_rs1", rs1_to_ex_out, 0);
        chk("async_rst_imm", imm_to_ex_out, 0);
        chk("async_rst_funct3", funct3_to_ex_out, 0);
        chk("async_rst_full", rs_full_out, 0);
        tick();
        rst_in = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    always @(negedge clk_in) begin
        if (!rst_in && dispatch_valid_in && rs_full_out) begin
            // Intentional drop exercised once in the full-buffer step.
        end
    end

endmodule : tb_alu_reservation_station
`default_nettype wire
